// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module : seg_scan_driver
// Brief  : 4-digit 7-segment scan driver with frame-aligned (tear-free) value
//          commit. Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int PRESCALE = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        enable,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        pending,
    output logic        frame_done
);

    localparam int             CW     = $clog2(PRESCALE);
    localparam logic [CW-1:0]  C_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] pcnt;
    logic [1:0]    idx;
    logic [15:0]   shown;
    logic [15:0]   pend_val;
    logic          tick;
    logic          commit;
    logic [3:0]    nibble;
    logic          blank;
    logic [6:0]    seg_dec;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    assign tick   = (pcnt == C_LAST);
    assign commit = tick && (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt       <= '0;
            idx        <= 2'd0;
            shown      <= 16'h0000;
            pend_val   <= 16'h0000;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            seg        <= 7'b1111111;
            an         <= 4'b1111;
        end else begin
            pcnt       <= tick ? '0 : pcnt + 1'b1;
            frame_done <= commit;
            seg        <= seg_next;
            an         <= an_next;
            if (tick) begin
                idx <= idx + 2'd1;
            end
            // The commit reads the old pend_val even when a load lands on the same edge.
            if (commit && pending) begin
                shown <= pend_val;
            end
            if (load) begin
                pend_val <= value;
                pending  <= 1'b1;
            end else if (commit) begin
                pending  <= 1'b0;
            end
        end
    end

    always_comb begin
        nibble = shown[{idx, 2'b00} +: 4];
        case (nibble)
            4'h0:    seg_dec = 7'b1000000;
            4'h1:    seg_dec = 7'b1111001;
            4'h2:    seg_dec = 7'b0100100;
            4'h3:    seg_dec = 7'b0110000;
            4'h4:    seg_dec = 7'b0011001;
            4'h5:    seg_dec = 7'b0010010;
            4'h6:    seg_dec = 7'b0000010;
            4'h7:    seg_dec = 7'b1111000;
            4'h8:    seg_dec = 7'b0000000;
            4'h9:    seg_dec = 7'b0010000;
            4'hA:    seg_dec = 7'b0001000;
            4'hB:    seg_dec = 7'b0000011;
            4'hC:    seg_dec = 7'b1000110;
            4'hD:    seg_dec = 7'b0100001;
            4'hE:    seg_dec = 7'b0000110;
            default: seg_dec = 7'b0001110;
        endcase
    end

`ifdef SEG_SCAN_LZB_EN
    // A digit is blank when it and every more-significant digit are zero.
    always_comb begin
        case (idx)
            2'd3:    blank = (shown[15:12] == 4'h0);
            2'd2:    blank = (shown[15:8]  == 8'h00);
            2'd1:    blank = (shown[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        if (enable && !blank) begin
            seg_next = seg_dec;
            an_next  = ~(4'b0001 << idx);
        end else begin
            seg_next = 7'b1111111;
            an_next  = 4'b1111;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// Testbench for seg_scan_driver: randomized stimulus, frame-level reference
// model feeding an expected-output queue, and a decoupled negedge monitor.
module tb_seg_scan_driver;

    localparam int P = 4;

    localparam logic [6:0] DEC [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       pending;
        logic       fd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        enable;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;

    seg_scan_driver #(.PRESCALE(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .load       (load),
        .enable     (enable),
        .seg        (seg),
        .an         (an),
        .pending    (pending),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: n counts clock edges since reset; digit slot and frame
    // position are derived arithmetically from n.
    int          n;
    int          digit;
    logic        m_commit;
    logic        m_blank;
    logic [15:0] m_shown;
    logic [15:0] m_pend;
    logic        m_pending;
    logic [15:0] m_rest;
    exp_t        e;

    always @(posedge clk) begin
        if (rst) begin
            n         = 0;
            m_shown   = 16'h0;
            m_pend    = 16'h0;
            m_pending = 1'b0;
            e         = '{seg: 7'h7F, an: 4'hF, pending: 1'b0, fd: 1'b0};
        end else begin
            digit    = (n / P) % 4;
            m_commit = ((n % (4 * P)) == (4 * P - 1));
            m_rest   = m_shown >> (4 * digit);
            m_blank  = 1'b0;
`ifdef SEG_SCAN_LZB_EN
            m_blank  = (digit != 0) && (m_rest == 16'h0);
`endif
            if (enable && !m_blank) begin
                e.seg        = DEC[m_rest[3:0]];
                e.an         = 4'hF;
                e.an[digit]  = 1'b0;
            end else begin
                e.seg = 7'h7F;
                e.an  = 4'hF;
            end
            e.fd = m_commit;
            if (m_commit && m_pending) m_shown = m_pend;
            if (load) begin
                m_pend    = value;
                m_pending = 1'b1;
            end else if (m_commit) begin
                m_pending = 1'b0;
            end
            e.pending = m_pending;
            n = n + 1;
        end
        q.push_back(e);
    end

    exp_t me;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            checks = checks + 1;
            if ({seg, an, pending, frame_done} !== me) begin
                failures = failures + 1;
                if (failures <= 20)
                    $display("FAIL scan t=%0t got seg=%b an=%b pending=%b frame_done=%b want seg=%b an=%b pending=%b frame_done=%b",
                             $time, seg, an, pending, frame_done, me.seg, me.an, me.pending, me.fd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        load   = 1'b0;
        value  = 16'h0;
        enable = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (20) step();

        value = 16'h1234;
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (40) step();

        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            load = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 4))
                0:       value = 16'($urandom);
                1:       value = 16'($urandom) & 16'h0FFF;
                2:       value = 16'($urandom) & 16'h00FF;
                3:       value = 16'($urandom) & 16'h000F;
                default: value = 16'h0000;
            endcase
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            step();
        end

        rst  = 1'b0;
        load = 1'b0;
        repeat (3) step();
        @(negedge clk);
        #1;
        checks = checks + 1;
        if (q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL queue_drain got %0d entries want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed scan driver for the 4-digit, 7-segment display. It takes a 16-bit hex value and produces one `seg`/`an` pair per digit slot, rotating through the four digits at a prescaled rate. It latches new values only at frame boundaries so a digit never changes in the middle of a scan. Its `seg`/`an` outputs are the per-mode segment/anode inputs consumed by the display multiplexer.

## Interface
- `PRESCALE`, default 100000: clock cycles per digit slot; legal values are 2 or more (100 MHz gives 1 kHz per digit).
- `clk` in 1: the only clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `value` in 16: hex value to display. Nibble [3:0] is the rightmost digit (`an[0]`).
- `load` in 1: single-cycle strobe that captures `value` into the pending register.
- `enable` in 1: display enable; 0 forces the display dark.
- `seg` out 7: active-low segments, bit0=a … bit6=g; registered.
- `an` out 4: active-low anodes, one-hot-low; registered.
- `pending` out 1: high while a loaded value is waiting to be committed.
- `frame_done` out 1: one-cycle pulse at the end of each four-digit frame.

## Operation
- **Prescaler:** `pcnt` counts 0..PRESCALE-1 and wraps.
  - `tick` is asserted when `pcnt == PRESCALE-1`.
- **Digit index:** `idx` (2 bits) advances on `tick` in the order 0→1→2→3→0.
- **Commit:** on `tick` with `idx == 3`:
  - `shown <= pend_val` if `pending` is set; `pending` then clears.
  - `frame_done` pulses on the following cycle (registered).
- **Load:**
  - `load` sets `pend_val <= value` and `pending <= 1`.
  - Repeated loads before a commit overwrite the pending value; the last one wins.
- **Load coincident with commit:** the commit uses the old `pend_val`. The new value becomes pending and `pending` stays 1.
- **Decode** (active-low, gfedcba), applied to the nibble `shown[4*idx+3 -: 4]`:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **Anodes:** `an = ~(4'b0001 << idx)`.
- **Dark state:** when `enable` is 0, `an = 4'b1111` and `seg = 7'b1111111`. Scanning, commit and `frame_done` continue unaffected.
- **Reset values:** `pcnt=0`, `idx=0`, `shown=0`, `pend_val=0`, `pending=0`, `seg=7'b1111111`, `an=4'b1111`, `frame_done=0`.
- **Reset mid-frame:** any in-progress frame and any pending value are discarded.

## Timing
- `seg`/`an` are registered and lag `idx`/`shown`/`enable` by one cycle.
- **After reset release:**
  - First cycle: outputs are still at their reset values.
  - From the second cycle: `an=1110`, `seg=1000000` (digit 0 of 0x0000).
- Each digit is displayed for exactly `PRESCALE` cycles; a frame is `4*PRESCALE` cycles.
- **Commit latency:**
  - `shown` is updated on the `tick` edge that ends digit 3.
  - New digit 0 appears on `seg` one cycle later.
  - `pending` falls on the same edge as the commit.
- `frame_done` is high for exactly one cycle per frame, including frames with no pending value.
- `load` is sampled on every edge; a strobe held for N cycles acts as N loads (last value wins).
- `rst` has priority over `load`, `tick` and `enable`.

## Configuration
- **`SEG_SCAN_LZB_EN` defined:** leading-zero blanking.
  - Digit k (k = 3..1) is blanked when `shown[15:4k]` is all zero: its `an` bit is 1 and `seg` is 7'b1111111 during its slot.
  - Digit 0 is never blanked.
  - Examples: 0x0000 shows only "0"; 0x0050 shows "50"; 0x1000 shows all four digits.
- **Undefined:** all four digits are always driven.

## Test plan
- **Reset:** PRESCALE=4. Hold `rst` 3 cycles, then release → 1 cycle at `an=1111`/`seg=1111111`, then `an=1110`/`seg=1000000` for 4 cycles, then `an=1101`.
- **Scan:** load 0x1234, wait for the commit → repeating sequence `an=1110/seg=0011001`, `1101/0110000`, `1011/0100100`, `0111/1111001`, 4 cycles each; `frame_done` pulses once per 16 cycles.
- **Tear-free:** load 0xABCD during the digit-1 slot → `pending=1`, digits keep showing 0x0000 until the end of digit 3, then `pending=0` and digit 0 shows `0100001` (d).
- **Coincident load:** `load` with 0x00F0 on the commit-tick cycle, 0x1111 pending → 0x1111 is displayed, `pending` stays 1, 0x00F0 is displayed one frame later.
- **Enable:** drop `enable` mid-digit-2 → next cycle `an=1111`/`seg=1111111`; `frame_done` still pulses; restoring `enable` resumes at the current `idx`.
- **LZB (`SEG_SCAN_LZB_EN`):** commit 0x0050 → digits 3 and 2 blanked (`an` bits 1), digit 1 `seg=0010010`, digit 0 `seg=1000000`. Without the macro, digits 3 and 2 show `1000000`.
